// File: rtl/dmem_bridge_pkg.sv
// Shared types and defaults for the data-memory bridge.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
  localparam int          TIMEOUT_DEF  = 64;
  localparam int          WORD_BYTES   = 4;
  localparam int          OFS_BITS     = $clog2(WORD_BYTES);

  // True when the byte address sits on a word boundary.
  function automatic logic is_aligned(input logic [31:0] a);
    return a[OFS_BITS-1:0] == '0;
  endfunction

  // Byte address with the within-word offset bits cleared.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:OFS_BITS], {OFS_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/dmem_bridge_timeout.sv
// Saturating cycle counter that flags when an access has used its whole budget.
// Latency: expired_o is combinational from the count and en_i.
// Backpressure: none; the count holds at its last value until cleared.
// Ports: clk/reset, clear_i (restart at 0), en_i (count this cycle),
//        expired_o (high while enabled on the last budgeted cycle).
module timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // Saturate at LAST so a grant taken on the final cycle cannot wrap the
  // count and buy the following read phase a fresh budget.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the core's single-cycle data-memory request onto a req/gnt/rvalid bus.
// Latency: read stalls 3 cycles, write 2 (gnt in first REQ cycle, rvalid next).
// Backpressure: stall holds the core until DONE; TIMEOUT cycles abort with err.
// Ports: clk, reset (async, active low); core side memread/memwrite/addr/wdata
//        in, readdata/stall/err out; bus side mem_req/mem_we/mem_addr/mem_wdata
//        out (registered), mem_gnt/mem_rvalid/mem_rdata in.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int          TIMEOUT  = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  state_e      state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic        err_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] rdata_q;

  logic access;
  logic start;
  logic bad;
  logic busy;
  logic expired;

  assign access = memread | memwrite;
  assign start  = (state_q == ST_IDLE) && access && is_aligned(addr);
  assign bad    = (state_q == ST_IDLE) && access && !is_aligned(addr);
  assign busy   = (state_q == ST_REQ) || (state_q == ST_WAIT);

  timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (start),
    .en_i      (busy),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= memwrite;  // read+write together is a write
            mem_addr_q  <= word_addr(addr);
            mem_wdata_q <= wdata;
          end
        end
        ST_REQ: begin
          // A grant on the last budgeted cycle still counts as completion.
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= mem_we_q ? ST_DONE : ST_WAIT;
          end else if (expired) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            if (!mem_we_q) rdata_q <= ERR_DATA;
            state_q   <= ST_DONE;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            rdata_q <= mem_rdata;
            state_q <= ST_DONE;
          end else if (expired) begin
            err_q   <= 1'b1;
            rdata_q <= ERR_DATA;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Combinational terms are gated with reset so every output shows its
  // reset value while reset is held, even if the core keeps requesting.
  assign stall     = reset && (start || busy);
  assign err       = reset && (err_q || bad);
  assign readdata  = (reset && bad && memread && !memwrite) ? ERR_DATA : rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed table, corner sequences, random traffic.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: the bench plays the memory, granting and returning data with set delays.
module tb_dmem_bridge;

  localparam int          TMO = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] readdata;
  logic        stall;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    int          gdly;
    int          rdly;
    bit          respond;
    int          e_stall;
    int          e_req;
    int          e_err;
    bit          chk_rd;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl [11];

  dmem_bridge #(
    .TIMEOUT  (TMO),
    .ERR_DATA (ERR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memread    (memread),
    .memwrite   (memwrite),
    .addr       (addr),
    .wdata      (wdata),
    .readdata   (readdata),
    .stall      (stall),
    .err        (err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] bus_read(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one core access and acts as the memory until the core is released.
  task automatic run_access(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input int gdly, input int rdly,
                            input bit respond,
                            output int stall_n, output int req_n, output int err_n,
                            output logic [31:0] rd_done, output logic we_seen,
                            output logic [31:0] addr_seen, output logic [31:0] wdata_seen,
                            output bit done);
    int gnt_at;
    bit is_rd;
    is_rd      = rd && !wr;
    stall_n    = 0;
    req_n      = 0;
    err_n      = 0;
    rd_done    = '0;
    we_seen    = 1'b0;
    addr_seen  = '0;
    wdata_seen = '0;
    done       = 1'b0;
    gnt_at     = -1;
    memread    = rd;
    memwrite   = wr;
    addr       = a;
    wdata      = wd;
    for (int c = 0; c < 4 * TMO && !done; c++) begin
      mem_gnt    = mem_req && (req_n == gdly) && (respond || is_rd);
      mem_rvalid = respond && is_rd && (gnt_at >= 0) && (c == gnt_at + 1 + rdly);
      mem_rdata  = mem_rvalid ? bus_read(mem_addr) : $urandom;
      @(negedge clk);
      if (mem_req && req_n == 0) begin
        we_seen    = mem_we;
        addr_seen  = mem_addr;
        wdata_seen = mem_wdata;
      end
      if (mem_req) req_n++;
      if (err) err_n++;
      if (mem_gnt) begin
        gnt_at = c;
        if (mem_we) bus_mem[mem_addr] = mem_wdata;
      end
      if (stall) stall_n++;
      else begin
        done    = 1'b1;
        rd_done = readdata;
      end
      next_cycle();
    end
    memread    = 1'b0;
    memwrite   = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    int sn, rn, en;
    logic [31:0] rdd, as, ws;
    logic wes;
    bit dn;
    run_access(v.rd, v.wr, v.a, v.wd, v.gdly, v.rdly, v.respond,
               sn, rn, en, rdd, wes, as, ws, dn);
    chk({tag, " done"}, 32'(dn), 32'd1);
    chk({tag, " stall_cycles"}, 32'(sn), 32'(v.e_stall));
    chk({tag, " req_cycles"}, 32'(rn), 32'(v.e_req));
    chk({tag, " err_pulses"}, 32'(en), 32'(v.e_err));
    if (v.chk_rd) chk({tag, " readdata"}, rdd, v.e_rdata);
    if (v.e_req > 0) begin
      chk({tag, " mem_we"}, 32'(wes), 32'(v.wr));
      chk({tag, " mem_addr"}, as, v.a - (v.a % 4));
      if (v.wr) chk({tag, " mem_wdata"}, ws, v.wd);
    end
  endtask

  initial begin
    vec_t v;
    int   kind;
    reset      = 1'b0;
    memread    = 1'b1;   // request held during reset must not leak out
    memwrite   = 1'b0;
    addr       = 32'h10;
    wdata      = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;

    //          rd wr  addr         wdata         g  r  rsp stall req err chk  rdata
    tbl[0]  = '{1, 0, 32'h10, 32'h0,        0, 0, 1,  3,   1,  0,  1, 32'h12345678};
    tbl[1]  = '{0, 1, 32'h20, 32'hCAFEF00D, 4, 0, 1,  6,   5,  0,  0, 32'h0};
    tbl[2]  = '{1, 0, 32'h30, 32'h0,        0, 0, 0,  9,   1,  1,  1, ERR};
    tbl[3]  = '{1, 0, 32'h13, 32'h0,        0, 0, 1,  0,   0,  1,  1, ERR};
    tbl[4]  = '{1, 1, 32'h40, 32'h0BADF00D, 0, 0, 1,  2,   1,  0,  0, 32'h0};
    tbl[5]  = '{1, 0, 32'h44, 32'h0,        1, 2, 1,  6,   2,  0,  1, 32'h44444444};
    tbl[6]  = '{1, 0, 32'h20, 32'h0,        0, 3, 1,  6,   1,  0,  1, 32'hCAFEF00D};
    tbl[7]  = '{0, 1, 32'h60, 32'h600D600D, 0, 0, 0,  9,   8,  1,  0, 32'h0};
    tbl[8]  = '{1, 0, 32'h40, 32'h0,        3, 3, 1,  9,   4,  0,  1, 32'h0BADF00D};
    tbl[9]  = '{0, 1, 32'h22, 32'h77777777, 0, 0, 1,  0,   0,  1,  0, 32'h0};
    tbl[10] = '{1, 0, 32'h20, 32'h0,        2, 1, 1,  6,   3,  0,  1, 32'hCAFEF00D};

    bus_mem[32'h10] = 32'h12345678;
    bus_mem[32'h44] = 32'h44444444;
    bus_mem[32'h50] = 32'h50505050;

    #2;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    chk("reset readdata", readdata, 32'h0);
    memread = 1'b0;
    next_cycle();
    reset = 1'b1;
    next_cycle();

    for (int i = 0; i < 11; i++) apply_vec($sformatf("row%0d", i), tbl[i]);

    // Late rvalid after a timed-out read must not disturb anything.
    apply_vec("late_to", '{1, 0, 32'h34, 32'h0, 1, 0, 0, 9, 2, 1, 1, ERR});
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11111111;
    @(negedge clk);
    chk("late readdata", readdata, ERR);
    chk("late stall", 32'(stall), 32'd0);
    chk("late mem_req", 32'(mem_req), 32'd0);
    chk("late err", 32'(err), 32'd0);
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("late readdata hold", readdata, ERR);
    next_cycle();

    // Reset asserted while the bridge waits for read data.
    memread = 1'b1;
    addr    = 32'h50;
    @(negedge clk);
    chk("rstseq idle stall", 32'(stall), 32'd1);
    next_cycle();
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("rstseq req", 32'(mem_req), 32'd1);
    next_cycle();
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("rstseq wait stall", 32'(stall), 32'd1);
    chk("rstseq wait req", 32'(mem_req), 32'd0);
    reset = 1'b0;
    #1;
    chk("rstseq stall", 32'(stall), 32'd0);
    chk("rstseq mem_req", 32'(mem_req), 32'd0);
    chk("rstseq mem_we", 32'(mem_we), 32'd0);
    chk("rstseq mem_addr", mem_addr, 32'h0);
    chk("rstseq err", 32'(err), 32'd0);
    chk("rstseq readdata", readdata, 32'h0);
    next_cycle();
    reset = 1'b1;
    apply_vec("post_rst", '{1, 0, 32'h50, 32'h0, 0, 0, 1, 3, 1, 0, 1, 32'h50505050});

    // Random traffic against an arithmetic reference model.
    for (int i = 0; i < 40; i++) begin
      kind      = int'($urandom_range(0, 7));
      v.a       = 32'h100 + 32'($urandom_range(0, 15) * 4);
      v.wd      = $urandom;
      v.gdly    = int'($urandom_range(0, 3));
      v.rdly    = int'($urandom_range(0, 3));
      v.respond = ($urandom_range(0, 4) != 0);
      v.rd      = (kind <= 2) || (kind == 5) || (kind == 6);
      v.wr      = (kind == 3) || (kind == 4) || (kind == 5) || (kind == 7);
      if (kind >= 6) v.a = v.a + 32'($urandom_range(1, 3));
      v.chk_rd  = v.rd && !v.wr;
      if ((v.a % 4) != 0) begin
        v.e_stall = 0;
        v.e_req   = 0;
        v.e_err   = 1;
        v.e_rdata = ERR;
      end else if (v.respond) begin
        v.e_req   = v.gdly + 1;
        v.e_stall = 1 + v.gdly + 1 + (v.chk_rd ? v.rdly + 1 : 0);
        v.e_err   = 0;
        v.e_rdata = ref_read(v.a);
        if (v.wr) ref_mem[v.a] = v.wd;
      end else begin
        v.e_req   = v.chk_rd ? v.gdly + 1 : TMO;
        v.e_stall = 1 + TMO;
        v.e_err   = 1;
        v.e_rdata = ERR;
      end
      apply_vec($sformatf("rnd%0d", i), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
